imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time controller for the single-cycle core's instruction memory (NUM_OF_INST words, NOP = 32'h00000013 fill).
//  Receives a program as a byte stream (valid/ready) and assembles little-endian 32-bit words.
//  Writes the words to consecutive word addresses from 0, holding the CPU in reset while it loads.
//  Owns the imem address port: muxes loader address vs. CPU PC, releases the CPU once the load completes.
// PARAMETERS
//  NUM_OF_INST  1024   instruction memory depth in words
//  TIMEOUT      65535  idle cycles allowed between bytes in LOAD before error
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   1-cycle pulse: begin load (sampled in IDLE/DONE/ERR)
//  word_count   in   11  number of words to load, legal 1..NUM_OF_INST
//  byte_valid   in   1   byte_data valid
//  byte_data    in   8   program byte, little-endian within each word
//  byte_ready   out  1   loader accepts byte this cycle
//  pc_address   in   32  CPU fetch byte address
//  imem_addr    out  32  byte address to inst_mem
//  mem_we       out  1   write strobe to inst_mem (1 cycle per word)
//  mem_wdata    out  32  assembled instruction word
//  cpu_rst      out  1   reset to core; high until load completes
//  busy         out  1   state == LOAD
//  done         out  1   state == DONE
//  error        out  1   state == ERR
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; cpu_rst=1; byte_ready=mem_we=busy=done=error=0;
//   mem_wdata=0, word ptr=0, byte idx=0, idle counter=0. Reset mid-LOAD aborts; written words stay as written.
//  FSM: IDLE -start-> LOAD or ERR; LOAD -last byte-> DONE; LOAD -timeout-> ERR; DONE/ERR -start-> LOAD or ERR.
//  start check: word_count==0 or >NUM_OF_INST -> ERR; else LOAD with ptr=0, idx=0, count latched.
//  start while in LOAD is ignored; word_count is only sampled on an accepted start.
//  LOAD: byte_ready=1 every cycle; a byte is accepted when byte_valid & byte_ready.
//   Byte at idx k goes to word[8k+7:8k]; idx wraps 3->0.
//  On acceptance of idx 3: next cycle mem_we=1, mem_wdata=full word, imem_addr={ptr,2'b00}; ptr increments.
//   Write pulse is 1 cycle. Streaming continues without a stall; a byte may be accepted in the same cycle as mem_we.
//  Last word (ptr==count-1, idx 3 accepted): state->DONE, and that word's mem_we still issues in the following cycle.
//  No byte is accepted after the last one (byte_ready=0 outside LOAD).
//  Idle counter: resets on each accepted byte; reaching TIMEOUT in LOAD -> ERR, dropping the partial word (no write).
//  imem_addr: ={ptr,2'b00} during LOAD and during the trailing write cycle; otherwise =pc_address.
//  cpu_rst: 1 in IDLE/LOAD/ERR and during the trailing write cycle; 0 from the first cycle after it in DONE.
//  Restart from DONE reasserts cpu_rst the cycle after start.
//  ptr width = clog2(NUM_OF_INST); ptr never exceeds count-1, so addresses stay in range.
// TESTING
//  1: reset, start word_count=2, bytes 33 00 10 00 13 01 20 00 -> mem_we @ addr 0x0 data 0x00100033,
//     @ 0x4 data 0x00200113; then done=1, cpu_rst=0, imem_addr follows pc_address=0x8.
//  2: word_count=1024, continuous bytes -> 1024 write pulses, last at addr 0xFFC; no write at 0x1000; done=1.
//  3: start with word_count=0, then separately with 1025 -> error=1, cpu_rst=1, no mem_we, byte_ready=0.
//  4: word_count=2, send 5 bytes then stall TIMEOUT cycles -> error=1, exactly one write (addr 0x0), partial word dropped.
//  5: rst=1 mid-LOAD after 6 bytes -> next cycle IDLE, cpu_rst=1, busy=0; a new start reloads from addr 0x0.
//  6: byte_valid toggling 1/0 each cycle plus a start pulse mid-LOAD -> start ignored, words assembled correctly,
//     DONE restart via start reasserts cpu_rst.

Source files
------------

// File: rtl/imem_boot_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time controller for the core's instruction memory. It receives a
//   program as a byte stream (valid/ready) and assembles little-endian 32-bit
//   words. It writes the words to consecutive word addresses starting at 0,
//   and keeps the CPU in reset while the load runs. It owns the imem address
//   port and releases the CPU once the last word has been written.
//
// Ports
//   clk          in   1   single clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   start        in   1   one-cycle pulse, begins a load (IDLE/DONE/ERR only)
//   word_count   in   11  words to load, legal 1..NUM_OF_INST
//   byte_valid   in   1   byte_data valid
//   byte_data    in   8   program byte, little-endian within a word
//   byte_ready   out  1   loader accepts a byte this cycle
//   pc_address   in   32  CPU fetch byte address
//   imem_addr    out  32  byte address to the instruction memory
//   mem_we       out  1   one-cycle write strobe per word
//   mem_wdata    out  32  assembled instruction word
//   cpu_rst      out  1   core reset, high until the load completes
//   busy         out  1   loading
//   done         out  1   load complete
//   error        out  1   bad word_count or byte timeout
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int NUM_OF_INST = 1024,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] pc_address,
  output logic [31:0] imem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int PW = (NUM_OF_INST > 1) ? $clog2(NUM_OF_INST) : 1;
  localparam int AZ = 32 - PW - 2;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [10:0]   MAX_WORDS = 11'(NUM_OF_INST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t         state_r,   state_next_s;
  logic [PW-1:0]  ptr_r,     ptr_next_s;
  logic [PW-1:0]  waddr_r,   waddr_next_s;
  logic [1:0]     idx_r,     idx_next_s;
  logic [31:0]    asm_r,     asm_next_s;
  logic [10:0]    count_r,   count_next_s;
  logic [IW-1:0]  idle_r,    idle_next_s;
  logic           we_r,      we_next_s;
  logic [31:0]    wdata_r,   wdata_next_s;

  logic accept_s;
  logic start_ok_s;
  logic last_word_s;

  assign accept_s    = byte_valid & (state_r == ST_LOAD);
  assign start_ok_s  = (word_count != 11'd0) && (word_count <= MAX_WORDS);
  assign last_word_s = (11'(ptr_r) == (count_r - 11'd1));

  assign byte_ready = (state_r == ST_LOAD);
  assign busy       = (state_r == ST_LOAD);
  assign done       = (state_r == ST_DONE);
  assign error      = (state_r == ST_ERR);
  assign mem_we     = we_r;
  assign mem_wdata  = wdata_r;

  // The write cycle uses the latched write address: ptr has already moved on.
  assign imem_addr = we_r ? {{AZ{1'b0}}, waddr_r, 2'b00} :
                     (state_r == ST_LOAD) ? {{AZ{1'b0}}, ptr_r, 2'b00} :
                     pc_address;

  // The core stays in reset until the trailing write of the last word retires.
  assign cpu_rst = ~((state_r == ST_DONE) & ~we_r);

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    waddr_next_s = waddr_r;
    idx_next_s   = idx_r;
    asm_next_s   = asm_r;
    count_next_s = count_r;
    idle_next_s  = idle_r;
    we_next_s    = 1'b0;
    wdata_next_s = wdata_r;

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (start_ok_s) begin
            state_next_s = ST_LOAD;
            ptr_next_s   = '0;
            idx_next_s   = 2'd0;
            asm_next_s   = 32'd0;
            idle_next_s  = '0;
            count_next_s = word_count;
          end else begin
            state_next_s = ST_ERR;
          end
        end else begin
          state_next_s = state_r;
        end
      end

      ST_LOAD: begin
        if (accept_s) begin
          idle_next_s = '0;
          idx_next_s  = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            we_next_s    = 1'b1;
            wdata_next_s = {byte_data, asm_r[23:0]};
            waddr_next_s = ptr_r;
            if (last_word_s) begin
              // ptr stays on the last word so it never leaves the legal range
              state_next_s = ST_DONE;
            end else begin
              ptr_next_s = ptr_r + PW'(1);
            end
          end else begin
            asm_next_s[{idx_r, 3'b000} +: 8] = byte_data;
          end
        end else if (idle_r == IDLE_LAST) begin
          // the partial word is simply abandoned, nothing is written
          state_next_s = ST_ERR;
        end else begin
          idle_next_s = idle_r + IW'(1);
        end
      end

      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      waddr_r <= '0;
      idx_r   <= 2'd0;
      asm_r   <= 32'd0;
      count_r <= 11'd0;
      idle_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      waddr_r <= waddr_next_s;
      idx_r   <= idx_next_s;
      asm_r   <= asm_next_s;
      count_r <= count_next_s;
      idle_r  <= idle_next_s;
      we_r    <= we_next_s;
      wdata_r <= wdata_next_s;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
// Testbench for imem_boot_loader: directed scenarios plus randomized loads.
// Expected memory writes are derived from the byte stream sent: word i lands
// at byte address 4*i and holds bytes 4i..4i+3 in little-endian order.
module tb_imem_boot_loader;

  localparam int NI = 1024;
  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] pc_address;
  logic [31:0] imem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int bad_rst = 0;

  logic [63:0] wr_q[$];
  logic [7:0]  stream[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.NUM_OF_INST(NI), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pc_address(pc_address), .imem_addr(imem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .error(error)
  );

  // Record every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_q.push_back({imem_addr, mem_wdata});
      if (cpu_rst !== 1'b1) bad_rst++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_stream(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic do_start(input logic [10:0] wc);
    #1;
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
    word_count = 11'($urandom_range(0, 2047));
  endtask

  // Present one byte after 'gap' idle cycles; optionally pulse start in the gap.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int w;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (with_start && g == 0) begin
        start = 1'b1;
        word_count = 11'd0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    w = 0;
    while (byte_ready !== 1'b1 && w < 4) begin
      @(negedge clk);
      w++;
    end
    check("byte_ready", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n);
    logic [31:0] e_addr;
    logic [31:0] e_data;
    check({tag, "_count"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      e_addr = 32'(i * 4);
      e_data = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
      check({tag, "_addr"}, wr_q[i][63:32], e_addr);
      check({tag, "_data"}, wr_q[i][31:0], e_data);
    end
  endtask

  task automatic run_load(input string tag, input int wc, input int gmax);
    fill_stream(4 * wc);
    do_start(11'(wc));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 4 * wc; i++) send_byte(stream[i], $urandom_range(0, gmax), 1'b0);
    @(negedge clk);
    check({tag, "_trail_we"}, 32'(mem_we), 32'd1);
    check({tag, "_trail_addr"}, imem_addr, 32'((wc - 1) * 4));
    check({tag, "_trail_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, "_pc_mux"}, imem_addr, pc_address);
    repeat (2) @(negedge clk);
    check_writes(tag, wc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_count = 11'd0;
    byte_valid = 1'b0; byte_data = 8'd0; pc_address = $urandom;
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_addr", imem_addr, pc_address);
    rst = 1'b0;

    // 1: two-word program from the example
    stream.delete();
    stream = '{8'h33, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    pc_address = 32'h8;
    do_start(11'd2);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0, 1'b0);
    @(negedge clk);
    check("t1_trail_we", 32'(mem_we), 32'd1);
    check("t1_trail_addr", imem_addr, 32'h4);
    check("t1_trail_data", mem_wdata, 32'h00200113);
    check("t1_trail_rst", 32'(cpu_rst), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_ready_off", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("t1_we_off", 32'(mem_we), 32'd0);
    check("t1_cpu_run", 32'(cpu_rst), 32'd0);
    check("t1_pc_mux", imem_addr, 32'h8);
    check_writes("t1", 2);

    // 2: full-depth load, continuous stream
    pc_address = $urandom;
    run_load("t2", NI, 0);

    // 3: illegal word counts
    do_start(11'd0);
    check("t3a_error", 32'(error), 32'd1);
    check("t3a_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t3a_ready", 32'(byte_ready), 32'd0);
    check("t3a_busy", 32'(busy), 32'd0);
    check("t3a_pc_mux", imem_addr, pc_address);
    repeat (3) @(negedge clk);
    check("t3a_writes", 32'(wr_q.size()), 32'd0);
    do_start(11'd1025);
    check("t3b_error", 32'(error), 32'd1);
    check("t3b_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t3b_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("t3b_writes", 32'(wr_q.size()), 32'd0);

    // 4: timeout after a partial second word
    fill_stream(5);
    do_start(11'd2);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0, 1'b0);
    repeat (TO - 3) @(negedge clk);
    check("t4_still_busy", 32'(busy), 32'd1);
    check("t4_no_err_yet", 32'(error), 32'd0);
    repeat (6) @(negedge clk);
    check("t4_error", 32'(error), 32'd1);
    check("t4_busy_off", 32'(busy), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    check_writes("t4", 1);

    // 5: reset in the middle of a load, then reload
    fill_stream(6);
    do_start(11'd4);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t5_flags", {30'd0, done, error}, 32'd0);
    check("t5_ready", 32'(byte_ready), 32'd0);
    check_writes("t5", 1);
    run_load("t5r", 1, 2);

    // 6: toggling valid, ignored start mid-load, restart from DONE
    fill_stream(12);
    do_start(11'd3);
    for (int i = 0; i < 12; i++) send_byte(stream[i], 1, (i == 5));
    @(negedge clk);
    check("t6_trail_we", 32'(mem_we), 32'd1);
    check("t6_done", 32'(done), 32'd1);
    check("t6_error", 32'(error), 32'd0);
    @(negedge clk);
    check("t6_cpu_run", 32'(cpu_rst), 32'd0);
    check_writes("t6", 3);
    fill_stream(4);
    do_start(11'd1);
    check("t6_restart_rst", 32'(cpu_rst), 32'd1);
    check("t6_restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(stream[i], 0, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("t6b", 1);

    // 7: randomized loads with random gaps
    for (int k = 0; k < 6; k++) begin
      pc_address = $urandom;
      run_load("t7", $urandom_range(1, 8), 3);
    end

    check("cpu_rst_during_write", 32'(bad_rst), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
